// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// It runs one radix-2 step per cycle on a shared datapath: shift-add for
// multiply and restoring shift-subtract for divide. Signed operations work on
// operand magnitudes, and the result signs are restored in a final fix-up cycle.
//
// Ports:
//   clock      core clock
//   reset_n    synchronous active-low reset
//   req_valid  EX presents a request this cycle
//   req_op     0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   A, B       forwarded rs / rt operands
//   rd_hilo    EX is executing MFHI/MFLO this cycle
//   kill       pipeline flush; aborts any in-flight operation
//   busy       an operation is in progress (ITER or FIXUP)
//   stall      hold the pipeline: busy and (request or HI/LO read), unless killed
//   hi, lo     architectural HI/LO registers
module muldiv_unit (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        rd_hilo,
   input  logic        kill,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FIXUP = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // Magnitude of a 32-bit value, treated as two's complement when is_signed is set
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      if (is_signed && v[31]) begin
         mag32 = (~v) + 32'd1;
      end else begin
         mag32 = v;
      end
   endfunction

   // Conditional two's-complement negation, 32 bits
   function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
      if (neg) begin
         cneg32 = (~v) + 32'd1;
      end else begin
         cneg32 = v;
      end
   endfunction

   // Conditional two's-complement negation, 64 bits
   function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
      if (neg) begin
         cneg64 = (~v) + 64'd1;
      end else begin
         cneg64 = v;
      end
   endfunction

   state_t      state_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic [4:0]  count_r;
   // Multiply: [63:32] running partial sum, [31:0] multiplier being shifted out.
   // Divide:   [63:32] partial remainder,   [31:0] dividend shifting in quotient bits.
   logic [63:0] acc_r;
   logic [31:0] opb_r;      // multiplicand or divisor magnitude
   logic        is_div_r;
   logic        neg_res_r;  // negate product / quotient at fix-up
   logic        neg_rem_r;  // negate remainder at fix-up (dividend was negative)

   logic        op_signed_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [32:0] add_s;
   logic [33:0] trial_s;
   logic [63:0] step_s;
   logic [63:0] prod_s;
   logic [31:0] quo_s;
   logic [31:0] rem_s;

   assign busy  = (state_r != IDLE);
   assign stall = busy & (req_valid | rd_hilo) & ~kill;
   assign hi    = hi_r;
   assign lo    = lo_r;

   // Operand conditioning for a request arriving this cycle
   always_comb begin
      op_signed_s = (req_op == OP_MULT) || (req_op == OP_DIV);
      a_mag_s     = mag32(A, op_signed_s);
      b_mag_s     = mag32(B, op_signed_s);
   end

   // One radix-2 step of the shared shift/add-subtract datapath
   always_comb begin
      add_s   = 33'd0;
      trial_s = 34'd0;
      step_s  = acc_r;
      if (is_div_r) begin
         // Shifted partial remainder is 33 bits wide; a borrow into bit 33 means "restore"
         trial_s = {1'b0, acc_r[63:31]} - {2'b00, opb_r};
         if (trial_s[33]) begin
            step_s = {acc_r[62:0], 1'b0};
         end else begin
            step_s = {trial_s[31:0], acc_r[30:0], 1'b1};
         end
      end else begin
         if (acc_r[0]) begin
            add_s = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
         end else begin
            add_s = {1'b0, acc_r[63:32]};
         end
         step_s = {add_s, acc_r[31:1]};
      end
   end

   // Sign restoration applied in the fix-up cycle
   always_comb begin
      prod_s = cneg64(acc_r, neg_res_r);
      quo_s  = cneg32(acc_r[31:0], neg_res_r);
      rem_s  = cneg32(acc_r[63:32], neg_rem_r);
   end

   // Control FSM, HI/LO registers and datapath state
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
         count_r   <= 5'd0;
         acc_r     <= 64'd0;
         opb_r     <= 32'd0;
         is_div_r  <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && !kill) begin
                  case (req_op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        if (req_op[1] && (B == 32'd0)) begin
                           // Divide by zero resolves immediately without iterating
                           hi_r <= A;
                           lo_r <= 32'hFFFF_FFFF;
                        end else begin
                           acc_r     <= {32'd0, a_mag_s};
                           opb_r     <= b_mag_s;
                           is_div_r  <= req_op[1];
                           neg_res_r <= op_signed_s & (A[31] ^ B[31]);
                           neg_rem_r <= op_signed_s & A[31];
                           count_r   <= 5'd0;
                           state_r   <= ITER;
                        end
                     end
                     OP_MTHI: hi_r <= A;
                     OP_MTLO: lo_r <= A;
                     default: begin
                        // ops 6 and 7 are accepted and do nothing
                     end
                  endcase
               end
            end
            ITER: begin
               if (kill) begin
                  state_r <= IDLE;
               end else begin
                  acc_r   <= step_s;
                  count_r <= count_r + 5'd1;
                  if (count_r == 5'd31) begin
                     state_r <= FIXUP;
                  end
               end
            end
            FIXUP: begin
               state_r <= IDLE;
               if (!kill) begin
                  if (is_div_r) begin
                     hi_r <= rem_s;
                     lo_r <= quo_s;
                  end else begin
                     hi_r <= prod_s[63:32];
                     lo_r <= prod_s[31:0];
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clock     = 1'b0;
   logic        reset_n   = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op    = 3'd0;
   logic [31:0] A         = 32'd0;
   logic [31:0] B         = 32'd0;
   logic        rd_hilo   = 1'b0;
   logic        kill      = 1'b0;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   muldiv_unit dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
      .A(A), .B(B), .rd_hilo(rd_hilo), .kill(kill),
      .busy(busy), .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic        acc_q = 1'b0;
   logic        prev_busy = 1'b0;
   logic [63:0] mon_e;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Architectural {hi,lo} after an op, from plain arithmetic on the operands
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
      longint sa;
      longint sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: r = 64'(sa * sb);
         3'd1: r = {32'd0, a} * {32'd0, b};
         3'd2: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
               else r = {32'(sa % sb), 32'(sa / sb)};
         3'd3: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
               else r = {a % b, a / b};
         3'd4: r = {a, l};
         3'd5: r = {h, a};
         default: r = {h, l};
      endcase
      return r;
   endfunction

   // Monitor: note each accepting edge
   always @(posedge clock) acc_q <= reset_n && req_valid && !kill && !busy;

   // Monitor: whenever an op resolves (immediate accept or busy falling), compare HI/LO
   always @(negedge clock) begin
      if (!busy && (prev_busy || acc_q)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow got=%h want=queued_entry", {hi, lo});
         end else begin
            mon_e = exp_q.pop_front();
            check("hilo", {hi, lo}, mon_e);
         end
      end
      prev_busy = busy;
   end

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op = op;
      A = a;
      B = b;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!busy) break;
         n++;
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      int n;
      int want_n;
      r = model(op, a, b, m_hi, m_lo);
      exp_q.push_back(r);
      {m_hi, m_lo} = r;
      want_n = ((op <= 3'd1) || ((op <= 3'd3) && (b != 32'd0))) ? 33 : 0;
      start_op(op, a, b);
      wait_idle(n);
      check("busy_cycles", 64'(n), 64'(want_n));
   endtask

   // Start a DIV and kill it after wait_edges further edges; HI/LO must be untouched
   task automatic kill_test(input int wait_edges);
      exp_q.push_back({m_hi, m_lo});
      start_op(3'd2, 32'h0000_1000, 32'd3);
      repeat (wait_edges) @(posedge clock);
      #1;
      kill = 1'b1;
      rd_hilo = 1'b1;
      #1;
      check("kill_stall", 64'(stall), 64'd0);
      check("kill_busy_pre", 64'(busy), 64'd1);
      @(posedge clock);
      #1;
      kill = 1'b0;
      rd_hilo = 1'b0;
      check("kill_busy_post", 64'(busy), 64'd0);
      @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] r;
      int ns;
      int n;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      rd_hilo = 1'b1;
      #1;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      rd_hilo = 1'b0;
      @(negedge clock);

      run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
      run_op(3'd3, 32'd100, 32'd7);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd2, 32'h1234_5678, 32'd0);
      run_op(3'd5, 32'hCAFE_BABE, 32'd0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

      // MULTU with a HI/LO read and a queued MTHI held from T+2
      r = model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_hi, m_lo);
      exp_q.push_back(r);
      {m_hi, m_lo} = r;
      start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clock);
      #1;
      rd_hilo = 1'b1;
      req_valid = 1'b1;
      req_op = 3'd4;
      A = 32'h1357_9BDF;
      r = model(3'd4, 32'h1357_9BDF, 32'd0, m_hi, m_lo);
      exp_q.push_back(r);
      {m_hi, m_lo} = r;
      ns = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!busy) break;
         if (stall) ns++;
      end
      check("stall_cycles", 64'(ns), 64'd32);
      check("stall_released", 64'(stall), 64'd0);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      rd_hilo = 1'b0;
      @(negedge clock);
      check("held_req_immediate", 64'(busy), 64'd0);

      kill_test(9);
      kill_test(32);

      // kill in IDLE swallows a simultaneous request
      req_op = 3'd4;
      A = 32'hDEAD_0001;
      req_valid = 1'b1;
      kill = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      kill = 1'b0;
      check("kill_idle_hi", 64'(hi), 64'(m_hi));
      @(negedge clock);

      // reset in the middle of a MULT clears everything
      exp_q.push_back(64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      start_op(3'd0, 32'h0000_0123, 32'h0000_0456);
      repeat (4) @(posedge clock);
      #1;
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_hilo", {hi, lo}, 64'd0);
      @(negedge clock);
      run_op(3'd0, 32'd6, 32'd7);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'd1;
            2: b = 32'hFFFF_FFFF;
            3: a = 32'h8000_0000;
            4: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         run_op(op, a, b);
      end

      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clock);
      end
      check("sb_drain", 64'(exp_q.size()), 64'd0);
      wait_idle(n);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide controller owning the architectural HI/LO registers, placed beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and sequences a shared radix-2 shift/add–subtract datapath over 32 iterations. While it is busy it raises stall to the pipeline so that dependent HI/LO reads and new requests wait.

Parameters:
none (fixed 32-bit operands, 1 bit per iteration)

Ports:
clock  input  1  core clock
reset_n  input  1  synchronous active-low reset
req_valid  input  1  EX presents a mul/div/mthi/mtlo request this cycle
req_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 accepted as no-op
A  input  32  forwarded rs operand (multiplicand/dividend/move source)
B  input  32  forwarded rt operand (multiplier/divisor)
rd_hilo  input  1  EX is executing MFHI/MFLO this cycle
kill  input  1  pipeline flush; aborts any in-flight operation
busy  output  1  state != IDLE
stall  output  1  combinational: busy & (req_valid | rd_hilo) & ~kill
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Clock and reset: one clock (clock); reset_n is synchronous and active-low. On a clock edge with reset_n=0: state=IDLE, hi=0, lo=0, iteration count=0, internal accumulators cleared. Consequently busy=0 and stall=0. Reset mid-operation discards the operation.
- States: IDLE, ITER, FIXUP.
- IDLE, acceptance:
  - A request is accepted on an edge with req_valid=1 and kill=0.
  - MTHI/MTLO write hi/lo (respectively) with A at that edge and stay in IDLE.
  - Op 6 and op 7 do nothing.
  - DIV/DIVU with B==0: hi<=A, lo<=32'hFFFFFFFF at that edge; stay in IDLE.
  - All other mul/div ops latch |A|, |B| (magnitudes for signed ops, raw values for unsigned) plus sign flags, count<=0, and go to ITER.
- ITER, one iteration per cycle:
  - MULT/MULTU: shift-add producing a 64-bit unsigned product.
  - DIV/DIVU: restoring shift-subtract producing a 32-bit quotient and remainder.
  - count increments each cycle; after count==31 go to FIXUP.
- FIXUP (1 cycle):
  - Signed multiply: negate the 64-bit product if sign(A) xor sign(B).
  - Signed divide: quotient negated if sign(A) xor sign(B); remainder takes sign(A).
  - Writes {hi,lo}=product, or hi=remainder and lo=quotient, at the FIXUP edge, then go to IDLE.
- Latency: accept edge T; busy=1 for cycles T+1..T+33; hi/lo are valid in cycle T+34, when busy=0.
- Signed overflow: 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (falls out of the magnitude math).
- Busy interaction:
  - Any req_valid or rd_hilo while busy asserts stall in the same cycle. The request is not accepted.
  - EX must hold the request until stall drops.
  - The FIXUP cycle counts as busy. The first acceptable cycle is the one where busy=0.
- kill:
  - In ITER/FIXUP: go to IDLE at that edge with hi/lo unchanged (a FIXUP write is suppressed).
  - In IDLE: any simultaneous request is ignored.
  - stall is forced to 0 whenever kill=1.
- Simultaneous reset_n=0 and kill=1: reset wins.
- hi/lo change only on: MTHI/MTLO, divide-by-zero, FIXUP completion, or reset.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD (−3), B=5 → busy high for exactly 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU A=100, B=7 → after 33 busy cycles lo=14, hi=2. DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV A=0x12345678, B=0 → busy never rises; next cycle hi=0x12345678, lo=0xFFFFFFFF. Then MTLO A=0xCAFEBABE → lo=0xCAFEBABE, hi unchanged.
- MULTU 0xFFFFFFFF×0xFFFFFFFF with rd_hilo=1 and a second req_valid held from cycle T+2:
  - stall=1 through T+33.
  - In T+34: stall=0, hi=0xFFFFFFFE, lo=0x00000001.
  - The second request is accepted at the T+34 edge.
- Start DIV, assert kill at cycle T+10 → busy drops next cycle and hi/lo keep their pre-op values. Repeat with kill in the FIXUP cycle (T+33): hi/lo unchanged.
- Start MULT, drive reset_n=0 at T+5 for one cycle → hi=lo=0, busy=0 after the edge. A new MULT 6×7 then completes with lo=42, hi=0.
